// File: rtl/idct_pkg.sv
// idct_pkg: shared constants and types for the serial 8-point 1-D IDCT.
//   COS_TAB[n][k] : 1/2*c(k)*cos((2n+1)k*pi/16) in Q1.15, rounded to nearest.
//   Width helpers : input/output widths per pass (STAGE 0 = coefficients,
//                   STAGE 1 = level-shifted 8-bit pixels).
package idct_pkg;

  localparam int W_IN_S0   = 15;
  localparam int W_IN_S1   = 16;
  localparam int W_OUT_S0  = 16;
  localparam int W_OUT_S1  = 8;
  localparam int W_COEF    = 16;
  // 16x W_IN product plus 3 bits of growth for the 8-term sum.
  localparam int ACC_EXTRA = 19;
  localparam int FRAC_BITS = 15;
  localparam int ROUND_C   = 1 << 14;
  localparam int S16_MAX   = 32767;
  localparam int S16_MIN   = -32768;
  localparam int PIX_SHIFT = 128;
  localparam int PIX_MIN   = 0;
  localparam int PIX_MAX   = 255;

  localparam int COS_TAB [8][8] = '{
    '{11585,  16069,  15137,  13623,  11585,   9102,   6270,   3196},
    '{11585,  13623,   6270,  -3196, -11585, -16069, -15137,  -9102},
    '{11585,   9102,  -6270, -16069, -11585,   3196,  15137,  13623},
    '{11585,   3196, -15137,  -9102,  11585,  13623,  -6270, -16069},
    '{11585,  -3196, -15137,   9102,  11585, -13623,  -6270,  16069},
    '{11585,  -9102,  -6270,  16069, -11585,  -3196,  15137, -13623},
    '{11585, -13623,   6270,   3196, -11585,  16069, -15137,   9102},
    '{11585, -16069,  15137, -13623,  11585,  -9102,   6270,  -3196}
  };

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_RUN  = 1'b1
  } in_state_e;

  function automatic int w_in(input int stage);
    return (stage == 0) ? W_IN_S0 : W_IN_S1;
  endfunction

  function automatic int w_out(input int stage);
    return (stage == 0) ? W_OUT_S0 : W_OUT_S1;
  endfunction

endpackage

// File: rtl/idct_if.sv
// idct_if: row-level ena/rdy handshake bundle of one IDCT pass.
//   ena_in/rdy_out/a_in  : coefficient row input (upstream -> block)
//   ena_out/rdy_in/S_out : sample row output (block -> downstream)
//   master: the side that feeds coefficients and consumes samples.
//   slave : the idct_1d block.
interface idct_if #(parameter int STAGE = 0);
  import idct_pkg::*;

  localparam int W_IN  = w_in(STAGE);
  localparam int W_OUT = w_out(STAGE);

  logic                    ena_in;
  logic                    rdy_out;
  logic signed [W_IN-1:0]  a_in;
  logic                    ena_out;
  logic                    rdy_in;
  logic [W_OUT-1:0]        S_out;

  modport master (
    output ena_in, a_in, rdy_in,
    input  rdy_out, ena_out, S_out
  );

  modport slave (
    input  ena_in, a_in, rdy_in,
    output rdy_out, ena_out, S_out
  );

endinterface

// File: rtl/idct_out_buffer.sv
// idct_out_buffer: 8-entry parallel-load, serial-out sample register.
//   clk, rst : clock, async active-high reset
//   load     : capture din[0..7] (only asserted while free=1)
//   din      : converted samples y[0..7]
//   rdy_in   : downstream ready, looked at only before a row starts
//   ena_out  : s_out valid this cycle
//   s_out    : current sample y[idx]
//   free     : empty, or last sample leaving this cycle
module idct_out_buffer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din [8],
  input  logic         rdy_in,
  output logic         ena_out,
  output logic [W-1:0] s_out,
  output logic         free
);

  logic [W-1:0] data [8];
  logic         valid;
  logic         sending;
  logic [2:0]   idx;
  logic         last;

  // Once a row has started, rdy_in no longer gates the remaining samples.
  assign ena_out = valid && (sending || rdy_in);
  assign last    = ena_out && (idx == 3'd7);
  assign free    = !valid || last;
  assign s_out   = data[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      sending <= 1'b0;
      idx     <= 3'd0;
      for (int i = 0; i < 8; i++) data[i] <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      sending <= 1'b0;
      idx     <= 3'd0;
      data    <= din;
    end else if (ena_out) begin
      if (idx == 3'd7) begin
        valid   <= 1'b0;
        sending <= 1'b0;
        idx     <= 3'd0;
      end else begin
        sending <= 1'b1;
        idx     <= idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/idct_1d.sv
// idct_1d: serial 8-point 1-D inverse DCT, one row buffered.
//   clk, rst : clock, async active-high reset
//   bus      : idct_if slave (ena_in/rdy_out/a_in in, ena_out/rdy_in/S_out out)
//   STAGE    : 0 = saturated signed 16-bit output, 1 = +128 clamped 8-bit pixels
//
// Input FSM:
//   state   | meaning
//   IN_IDLE | waiting for X[0]; rdy_out possible
//   IN_RUN  | taking X[k], k = 1..7; a finished row raises pending
module idct_1d
  import idct_pkg::*;
#(
  parameter int STAGE = 0
) (
  input logic    clk,
  input logic    rst,
  idct_if.slave  bus
);

  localparam int W_IN   = w_in(STAGE);
  localparam int W_OUT  = w_out(STAGE);
  localparam int W_PROD = W_IN + W_COEF;
  localparam int W_ACC  = W_IN + ACC_EXTRA;

  in_state_e                 state;
  logic [2:0]                k;
  logic [2:0]                k_sel;
  logic                      pending;
  logic                      start;
  logic                      xfer;
  logic                      buf_free;
  logic signed [W_COEF-1:0]  coef [8];
  logic signed [W_PROD-1:0]  prod [8];
  logic signed [W_ACC-1:0]   acc  [8];
  logic signed [W_ACC-1:0]   rnd  [8];
  logic [W_OUT-1:0]          res  [8];

  assign start       = bus.ena_in && bus.rdy_out;
  assign xfer        = pending && buf_free;
  assign bus.rdy_out = (state == IN_IDLE) && (!pending || xfer);
  // X[0] arrives while still idle, so the column select is 0 there.
  assign k_sel       = (state == IN_RUN) ? k : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IN_IDLE;
      k       <= 3'd0;
      pending <= 1'b0;
    end else begin
      if (xfer) pending <= 1'b0;
      case (state)
        IN_IDLE: begin
          if (start) begin
            state <= IN_RUN;
            k     <= 3'd1;
          end
        end
        IN_RUN: begin
          if (k == 3'd7) begin
            state   <= IN_IDLE;
            k       <= 3'd0;
            pending <= 1'b1;
          end else begin
            k <= k + 3'd1;
          end
        end
        default: state <= IN_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      coef[n] = W_COEF'(COS_TAB[n][k_sel]);
      prod[n] = W_PROD'(bus.a_in) * W_PROD'(coef[n]);
    end
  end

  // Accumulators need no reset: a row always starts with a load.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 8; n++) begin
      if (start) begin
        acc[n] <= W_ACC'(prod[n]);
      end else if (state == IN_RUN) begin
        acc[n] <= acc[n] + W_ACC'(prod[n]);
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      rnd[n] = (acc[n] + W_ACC'(ROUND_C)) >>> FRAC_BITS;
    end
  end

  if (STAGE == 0) begin : g_sat
    always_comb begin
      for (int n = 0; n < 8; n++) begin
        if (rnd[n] > W_ACC'(S16_MAX)) begin
          res[n] = W_OUT'(S16_MAX);
        end else if (rnd[n] < W_ACC'(S16_MIN)) begin
          res[n] = W_OUT'(S16_MIN);
        end else begin
          res[n] = W_OUT'(rnd[n]);
        end
      end
    end
  end else begin : g_clamp
    logic signed [W_ACC-1:0] pix [8];
    always_comb begin
      for (int n = 0; n < 8; n++) begin
        pix[n] = rnd[n] + W_ACC'(PIX_SHIFT);
        if (pix[n] < W_ACC'(PIX_MIN)) begin
          res[n] = W_OUT'(PIX_MIN);
        end else if (pix[n] > W_ACC'(PIX_MAX)) begin
          res[n] = W_OUT'(PIX_MAX);
        end else begin
          res[n] = W_OUT'(pix[n]);
        end
      end
    end
  end

  idct_out_buffer #(
    .W(W_OUT)
  ) u_out_buffer (
    .clk     (clk),
    .rst     (rst),
    .load    (xfer),
    .din     (res),
    .rdy_in  (bus.rdy_in),
    .ena_out (bus.ena_out),
    .s_out   (bus.S_out),
    .free    (buf_free)
  );

endmodule
